// File: rtl/fwd_bypass_unit.sv
// Forwarding/hazard unit: tracks EX plus a DEPTH-deep retired-write history and
// resolves both issue operands to the youngest producer, stalling on load-use.

module fbu_src_resolve #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 2
) (
  input  logic [REG_AW-1:0]             rs,
  input  logic [DATA_W-1:0]             rf_rdata,
  input  logic                          ex_v,
  input  logic [REG_AW-1:0]             ex_rd,
  input  logic [1:0]                    ex_op,
  input  logic [DATA_W-1:0]             ex_imm,
  input  logic [DATA_W-1:0]             alu_result,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic [DEPTH-1:0]              h_v,
  input  logic [DEPTH-1:0][REG_AW-1:0]  h_rd,
  input  logic [DEPTH-1:0][DATA_W-1:0]  h_data,
  input  logic                          h0_pend,
  output logic [DATA_W-1:0]             data,
  output logic [2:0]                    sel,
  output logic                          haz
);
  always_comb begin
    data = rf_rdata;
    sel  = 3'd0;
    haz  = 1'b0;
    // oldest first so the youngest match overwrites
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (h_v[i] && h_rd[i] == rs) begin
        data = (i == 0 && h0_pend) ? mem_rdata : h_data[i];
        sel  = 3'(i + 2);
      end
    end
    if (ex_v && ex_rd == rs) begin
      sel = 3'd1;
      case (ex_op)
        2'b00:   data = ex_imm;
        2'b01:   data = alu_result;
        default: haz  = 1'b1;
      endcase
    end
  end
endmodule

module fwd_bypass_unit #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs0,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [1:0]        issue_op,
  input  logic [DATA_W-1:0] imm_val,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] rf_rdata0,
  input  logic [DATA_W-1:0] rf_rdata1,
  output logic              stall,
  output logic              op_valid,
  output logic [DATA_W-1:0] op0,
  output logic [DATA_W-1:0] op1,
  output logic [2:0]        fwd_sel0,
  output logic [2:0]        fwd_sel1,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } hent_t;

  logic              ex_v;
  logic [REG_AW-1:0] ex_rd;
  logic [1:0]        ex_op;
  logic [DATA_W-1:0] ex_imm;
  hent_t [DEPTH-1:0] hist;
  logic              h0_pend;   // H[0] holds a load whose data is on mem_rdata

  logic [DEPTH-1:0]                       h_v;
  logic [DEPTH-1:0][REG_AW-1:0]           h_rd;
  logic [DEPTH-1:0][DATA_W-1:0]           h_data;
  logic [NUM_SRC-1:0][REG_AW-1:0]         src_rs;
  logic [NUM_SRC-1:0][DATA_W-1:0]         src_rf;
  logic [NUM_SRC-1:0][DATA_W-1:0]         res_data;
  logic [NUM_SRC-1:0][2:0]                res_sel;
  logic [NUM_SRC-1:0]                     res_haz;
  logic                                   accept;

  assign src_rs = {issue_rs1, issue_rs0};
  assign src_rf = {rf_rdata1, rf_rdata0};

  for (genvar g = 0; g < DEPTH; g++) begin : g_unpk
    assign h_v[g]    = hist[g].v;
    assign h_rd[g]   = hist[g].rd;
    assign h_data[g] = hist[g].data;
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fbu_src_resolve #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) u_res (
      .rs(src_rs[s]), .rf_rdata(src_rf[s]),
      .ex_v(ex_v), .ex_rd(ex_rd), .ex_op(ex_op), .ex_imm(ex_imm),
      .alu_result(alu_result), .mem_rdata(mem_rdata),
      .h_v(h_v), .h_rd(h_rd), .h_data(h_data), .h0_pend(h0_pend),
      .data(res_data[s]), .sel(res_sel[s]), .haz(res_haz[s])
    );
  end

  assign stall  = issue_valid & ~flush & (|res_haz);
  assign accept = issue_valid & ~stall & ~flush;

  // EX and history advance every cycle; stall only withholds the issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v    <= 1'b0;
      ex_rd   <= '0;
      ex_op   <= '0;
      ex_imm  <= '0;
      hist    <= '0;
      h0_pend <= 1'b0;
    end else begin
      ex_v <= accept & (issue_op != 2'b11);
      if (accept) begin
        ex_rd  <= issue_rd;
        ex_op  <= issue_op;
        ex_imm <= imm_val;
      end
      hist[0].v    <= ex_v & ~flush;
      hist[0].rd   <= ex_rd;
      hist[0].data <= (ex_op == 2'b00) ? ex_imm : alu_result;
      h0_pend      <= (ex_op == 2'b10);
      for (int i = DEPTH-1; i > 0; i--) begin
        hist[i].v    <= hist[i-1].v & ~flush;
        hist[i].rd   <= hist[i-1].rd;
        hist[i].data <= (i == 1 && h0_pend) ? mem_rdata : hist[i-1].data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid  <= 1'b0;
      op0       <= '0;
      op1       <= '0;
      fwd_sel0  <= '0;
      fwd_sel1  <= '0;
      stall_cnt <= '0;
    end else begin
      op_valid <= accept;
      if (accept) begin
        op0      <= res_data[0];
        op1      <= res_data[1];
        fwd_sel0 <= res_sel[0];
        fwd_sel1 <= res_sel[1];
      end
      if (stall && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Bench for fwd_bypass_unit: directed vector table plus random traffic against a
// queue-based model of in-flight writers.

module tb_fwd_bypass_unit;
  localparam int DATA_W = 8, REG_AW = 3, DEPTH = 2, CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0, rst_n = 1'b0, flush = 1'b0, issue_valid = 1'b0;
  logic [REG_AW-1:0] issue_rs0 = '0, issue_rs1 = '0, issue_rd = '0;
  logic [1:0]        issue_op = '0;
  logic [DATA_W-1:0] imm_val = '0, alu_result = '0, mem_rdata = '0, rf_rdata0 = '0, rf_rdata1 = '0;
  logic              stall, op_valid;
  logic [DATA_W-1:0] op0, op1;
  logic [2:0]        fwd_sel0, fwd_sel1;
  logic [CNT_W-1:0]  stall_cnt;

  fwd_bypass_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid),
    .issue_rs0(issue_rs0), .issue_rs1(issue_rs1), .issue_rd(issue_rd), .issue_op(issue_op),
    .imm_val(imm_val), .alu_result(alu_result), .mem_rdata(mem_rdata),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .stall(stall), .op_valid(op_valid), .op0(op0), .op1(op1),
    .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: hq[0] is the instruction in EX, hq[k] (k>=1) is history entry k-1.
  typedef struct {bit v; bit [2:0] rd; bit [1:0] op; bit [7:0] d;} ment_t;
  ment_t hq[$];
  bit       m_vld;
  bit [7:0] m_op0, m_op1;
  bit [2:0] m_s0, m_s1;
  int       m_cnt;
  bit       last_stall;

  function automatic void m_reset();
    ment_t z = '{0, 0, 0, 0};
    hq.delete();
    for (int k = 0; k <= DEPTH; k++) hq.push_back(z);
    m_vld = 0; m_op0 = 0; m_op1 = 0; m_s0 = 0; m_s1 = 0; m_cnt = 0;
  endfunction

  function automatic void resolve(input bit [2:0] rs, input bit [7:0] rf,
                                  output bit [7:0] d, output bit [2:0] s, output bit hz);
    d = rf; s = 0; hz = 0;
    for (int k = 0; k <= DEPTH; k++) begin
      if (hq[k].v && hq[k].rd == rs) begin
        s = (k == 0) ? 3'd1 : 3'(k + 1);
        if (k == 0) begin
          if (hq[k].op == 2'b10) hz = 1;
          else d = (hq[k].op == 2'b00) ? hq[k].d : alu_result;
        end else if (k == 1 && hq[k].op == 2'b10) d = mem_rdata;
        else d = hq[k].d;
        break;
      end
    end
  endfunction

  // One clock: compare stall now, advance model, compare registered outputs after the edge.
  task automatic step();
    bit [7:0] d0, d1; bit [2:0] s0, s1; bit h0, h1, st, acc; ment_t e;
    #1;
    resolve(issue_rs0, rf_rdata0, d0, s0, h0);
    resolve(issue_rs1, rf_rdata1, d1, s1, h1);
    st  = issue_valid && !flush && (h0 || h1);
    acc = issue_valid && !st && !flush;
    last_stall = stall;
    chk("stall", stall, st);
    if (hq[1].op == 2'b10) begin e = hq[1]; e.d = mem_rdata; hq[1] = e; end
    if (hq[0].op == 2'b01) begin e = hq[0]; e.d = alu_result; hq[0] = e; end
    e = '{acc && issue_op != 2'b11, issue_rd, issue_op, imm_val};
    hq.push_front(e);
    void'(hq.pop_back());
    if (flush) for (int k = 0; k <= DEPTH; k++) begin e = hq[k]; e.v = 0; hq[k] = e; end
    m_vld = acc;
    if (acc) begin m_op0 = d0; m_op1 = d1; m_s0 = s0; m_s1 = s1; end
    if (st && m_cnt < CNT_MAX) m_cnt++;
    @(posedge clk); #1;
    chk("op_valid", op_valid, m_vld);
    chk("op0", op0, m_op0);
    chk("op1", op1, m_op1);
    chk("fwd_sel0", fwd_sel0, m_s0);
    chk("fwd_sel1", fwd_sel1, m_s1);
    chk("stall_cnt", stall_cnt, m_cnt);
  endtask

  task automatic do_reset();
    issue_valid = 0; flush = 0;
    rst_n = 0; #1;
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op0", op0, 0);
    chk("rst_op1", op1, 0);
    chk("rst_sel", {fwd_sel0, fwd_sel1}, 0);
    chk("rst_cnt", stall_cnt, 0);
    m_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit rst; bit iv; bit fl; bit [1:0] op; bit [2:0] rd, rs0, rs1;
    bit [7:0] imm, alu, mem, rf0;
    bit e_st; bit e_vld; bit [1:0] ck;
    bit [7:0] e_op0; bit [2:0] e_s0; bit [7:0] e_op1; bit [2:0] e_s1; bit [1:0] e_cnt;
  } vec_t;

  function automatic vec_t v(bit rst, bit iv, bit fl, bit [1:0] op, bit [2:0] rd, bit [2:0] rs0,
      bit [2:0] rs1, bit [7:0] imm, bit [7:0] alu, bit [7:0] mem, bit [7:0] rf0, bit e_st,
      bit e_vld, bit [1:0] ck, bit [7:0] e_op0, bit [2:0] e_s0, bit [7:0] e_op1, bit [2:0] e_s1,
      bit [1:0] e_cnt);
    vec_t r = '{rst, iv, fl, op, rd, rs0, rs1, imm, alu, mem, rf0, e_st, e_vld, ck,
                e_op0, e_s0, e_op1, e_s1, e_cnt};
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    //        rst iv fl op    rd rs0 rs1 imm    alu    mem    rf0    st vld ck     op0    s0 op1    s1 cnt
    tbl.push_back(v(1, 1, 0, 2'b01, 1, 6, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 0, 1, 2'b01, 8'hE0, 0, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 0, 2'b11, 0, 1, 7, 8'h00, 8'h3C, 8'h00, 8'hE0, 0, 1, 2'b01, 8'h3C, 1, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 0, 2'b00, 2, 6, 7, 8'hA5, 8'h00, 8'h00, 8'hE0, 0, 1, 2'b00, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 0, 2'b11, 0, 6, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 0, 1, 2'b00, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 0, 2'b11, 0, 6, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 0, 1, 2'b00, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 0, 2'b11, 0, 6, 2, 8'h00, 8'h00, 8'h00, 8'hE0, 0, 1, 2'b10, 8'h00, 0, 8'hA5, 3, 0));
    tbl.push_back(v(0, 1, 0, 2'b10, 3, 6, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 0, 1, 2'b00, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 0, 2'b11, 0, 3, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 1, 0, 2'b00, 8'h00, 0, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 0, 2'b11, 0, 3, 7, 8'h00, 8'h00, 8'h77, 8'hE0, 0, 1, 2'b01, 8'h77, 2, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 0, 2'b01, 4, 6, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 0, 1, 2'b00, 8'h00, 0, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 0, 2'b01, 4, 6, 7, 8'h00, 8'h22, 8'h00, 8'hE0, 0, 1, 2'b00, 8'h00, 0, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 0, 2'b11, 0, 4, 4, 8'h00, 8'h11, 8'h00, 8'hE0, 0, 1, 2'b11, 8'h11, 1, 8'h11, 1, 1));
    tbl.push_back(v(0, 1, 0, 2'b01, 5, 6, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 0, 1, 2'b00, 8'h00, 0, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 1, 2'b11, 0, 5, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 0, 0, 2'b00, 8'h00, 0, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 0, 2'b11, 0, 5, 7, 8'h00, 8'h00, 8'h00, 8'h5A, 0, 1, 2'b01, 8'h5A, 0, 8'h00, 0, 1));
    // chained load r3 <- r3: every dependent issue stalls once, counter saturates at 3
    tbl.push_back(v(1, 1, 0, 2'b10, 3, 6, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 0, 1, 2'b01, 8'hE0, 0, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 0, 2'b10, 3, 3, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 1, 0, 2'b00, 8'h00, 0, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 0, 2'b10, 3, 3, 7, 8'h00, 8'h00, 8'h10, 8'hE0, 0, 1, 2'b01, 8'h10, 2, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 0, 2'b10, 3, 3, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 1, 0, 2'b00, 8'h00, 0, 8'h00, 0, 2));
    tbl.push_back(v(0, 1, 0, 2'b10, 3, 3, 7, 8'h00, 8'h00, 8'h20, 8'hE0, 0, 1, 2'b01, 8'h20, 2, 8'h00, 0, 2));
    tbl.push_back(v(0, 1, 0, 2'b10, 3, 3, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 1, 0, 2'b00, 8'h00, 0, 8'h00, 0, 3));
    tbl.push_back(v(0, 1, 0, 2'b10, 3, 3, 7, 8'h00, 8'h00, 8'h30, 8'hE0, 0, 1, 2'b01, 8'h30, 2, 8'h00, 0, 3));
    tbl.push_back(v(0, 1, 0, 2'b10, 3, 3, 7, 8'h00, 8'h00, 8'h00, 8'hE0, 1, 0, 2'b00, 8'h00, 0, 8'h00, 0, 3));
    tbl.push_back(v(0, 1, 0, 2'b10, 3, 3, 7, 8'h00, 8'h00, 8'h40, 8'hE0, 0, 1, 2'b01, 8'h40, 2, 8'h00, 0, 3));

    m_reset();
    rf_rdata1 = 8'hE1;
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      issue_valid = tbl[i].iv; flush = tbl[i].fl; issue_op = tbl[i].op; issue_rd = tbl[i].rd;
      issue_rs0 = tbl[i].rs0; issue_rs1 = tbl[i].rs1; imm_val = tbl[i].imm;
      alu_result = tbl[i].alu; mem_rdata = tbl[i].mem; rf_rdata0 = tbl[i].rf0;
      step();
      chk($sformatf("v%0d_stall", i), last_stall, tbl[i].e_st);
      chk($sformatf("v%0d_vld", i), op_valid, tbl[i].e_vld);
      chk($sformatf("v%0d_cnt", i), stall_cnt, tbl[i].e_cnt);
      if (tbl[i].ck[0]) chk($sformatf("v%0d_op0", i), {fwd_sel0, op0}, {tbl[i].e_s0, tbl[i].e_op0});
      if (tbl[i].ck[1]) chk($sformatf("v%0d_op1", i), {fwd_sel1, op1}, {tbl[i].e_s1, tbl[i].e_op1});
    end

    // asynchronous reset while a load-use stall is being signalled
    issue_valid = 1; flush = 0; issue_op = 2'b11; issue_rs0 = 3; issue_rs1 = 7;
    #1;
    chk("mid_stall_pre", stall, 1);
    rst_n = 0; #1;
    chk("mid_rst_cnt", stall_cnt, 0);
    chk("mid_rst_vld", op_valid, 0);
    chk("mid_rst_stall", stall, 0);
    m_reset();
    @(negedge clk); rst_n = 1;
    rf_rdata0 = 8'h5A;
    step();
    chk("post_rst_op0", {fwd_sel0, op0}, {3'd0, 8'h5A});

    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      issue_valid = ($urandom_range(0, 99) < 85);
      flush       = ($urandom_range(0, 11) == 0);
      issue_op    = 2'($urandom_range(0, 3));
      issue_rd    = 3'($urandom_range(0, 3));
      issue_rs0   = 3'($urandom_range(0, 3));
      issue_rs1   = 3'($urandom_range(0, 3));
      imm_val     = 8'($urandom); alu_result = 8'($urandom); mem_rdata = 8'($urandom);
      rf_rdata0   = 8'($urandom); rf_rdata1  = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fwd_bypass_unit.md
Name: fwd_bypass_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined datapath.
- Tracks the destination of the instruction in EX and the last DEPTH retired writes in a shift history.
- Resolves each of the two source operands of the issuing instruction to the youngest matching producer, or to the register file when nothing matches.
- Stalls issue for one cycle on a load-use hazard; registers the resolved operands, their select codes and a saturating stall counter.

Parameters:
- DATA_W, 8, operand/result width
- REG_AW, 3, register address width
- DEPTH, 2, history entries behind EX (H[0]=MEM … H[DEPTH-1]); legal range 1..4
- CNT_W, 8, stall counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  kill EX and all history entries
- issue_valid  in  1  instruction presented for issue
- issue_rs0  in  REG_AW  source 0 address
- issue_rs1  in  REG_AW  source 1 address
- issue_rd  in  REG_AW  destination address
- issue_op  in  2  00=load-immediate, 01=ALU, 10=memory load, 11=no writeback
- imm_val  in  DATA_W  immediate, sampled at issue
- alu_result  in  DATA_W  result of the instruction currently in EX
- mem_rdata  in  DATA_W  load data for the instruction currently in H[0]
- rf_rdata0  in  DATA_W  register file value for rs0
- rf_rdata1  in  DATA_W  register file value for rs1
- stall  out  1  combinational; issue not accepted this cycle
- op_valid  out  1  registered; op0/op1 hold resolved operands
- op0  out  DATA_W  registered resolved source 0
- op1  out  DATA_W  registered resolved source 1
- fwd_sel0  out  3  source of op0: 0=RF, 1=EX, 2+i=H[i]
- fwd_sel1  out  3  source of op1: same encoding as fwd_sel0
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_n=0, immediate, asynchronous):
  - EX and all H valid bits = 0.
  - op_valid=0, op0=op1=0, fwd_sel0=fwd_sel1=0, stall_cnt=0.
- Accept condition: accept = issue_valid & ~stall & ~flush.
- EX register, on accept:
  - Loads ex_v = (issue_op != 11), ex_rd, ex_op, ex_imm = imm_val.
  - With no accept, EX becomes a bubble (ex_v=0).
- Advance every cycle (no hold on stall; stall only blocks issue):
  - H[i+1] <= H[i].
  - H[0] <= EX with data resolved: op 00 → ex_imm, op 01 → alu_result, op 10 → load pending (tag kept, data filled from mem_rdata).
  - When a pending load in H[0] shifts to H[1], H[1].data <= mem_rdata.
  - The oldest entry is dropped.
- Per-source match and priority, evaluated combinationally in the issue cycle for rs0 and rs1 independently:
  1. EX valid & rd match: op 00 → ex_imm; op 01 → alu_result; op 10 → hazard.
  2. Else youngest matching H[i]: pending load in H[0] → mem_rdata; otherwise the stored data.
  3. Else rf_rdata.
- stall = issue_valid & ~flush & (either source hits hazard).
  - Exactly one cycle per load-use, since the load moves to H[0] next cycle.
  - If rs0 and rs1 both hit the same load, still one stall cycle.
- Output register:
  - On accept: op_valid<=1; op0/op1 and fwd_sel0/1 <= resolved values.
  - Otherwise op_valid<=0 and op0/op1/fwd_sel hold their previous values.
  - Latency: issue cycle N → outputs valid cycle N+1.
- stall_cnt increments on each cycle with stall=1 and saturates at 2^CNT_W−1.
- flush:
  - Clears ex_v and all H valid bits at the next edge; op_valid<=0.
  - Suppresses stall and accept in the same cycle.
  - Flush takes priority over simultaneous issue.
- Matches against invalid entries or op 11 entries never forward.
- rs == rd of the issuing instruction itself is not a hazard; only older instructions are checked.
- A reset assertion mid-stall clears all state; after deassertion the first issue resolves from RF.

Test Plan:
- After reset, issue ALU r1←…; next cycle issue rs0=r1 with alu_result=8'h3C → op0=8'h3C, fwd_sel0=1, op_valid=1 one cycle later.
- Issue load-immediate r2 with imm_val=8'hA5, then two unrelated instructions, then rs1=r2 (DEPTH=2, entry in H[1]) → op1=8'hA5, fwd_sel1=3.
- Issue memory load r3, next cycle issue rs0=r3 → stall=1 for exactly one cycle, stall_cnt=1. Re-presented issue is then accepted with mem_rdata=8'h77 → op0=8'h77, fwd_sel0=2.
- Write r4 from both EX (alu_result=8'h11) and H[0] (data 8'h22), issue rs0=rs1=r4 → op0=op1=8'h11, fwd_sel=1 on both.
- Write r5 in EX, assert flush together with issue rs0=r5 → no accept, op_valid=0. Next issue rs0=r5 resolves to rf_rdata0=8'h5A with fwd_sel0=0.
- CNT_W=2, four back-to-back load-use stalls → stall_cnt sequence 1,2,3,3. Pulse rst_n low mid-stall → stall_cnt=0 and op_valid=0 immediately, without waiting for a clock edge.
